instr_word_encoder: RTL and testbench

//  Inverse of the core's instruction decode: packs decoded RV32I fields (format, funct3, alt bit, rd/rs1/rs2, imm)

---
 rtl/instr_word_encoder_pkg.sv | 38 +++
 rtl/instr_word_encoder_imm_range_check.sv | 44 ++++
 rtl/instr_word_encoder.sv | 135 +++++++++++++
 tb/tb_instr_word_encoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_word_encoder_pkg.sv
// Shared constants for the RV32I instruction word encoder: field widths,
// bundle format codes and the base opcodes the encoder emits.
package instr_word_encoder_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int FMT_WIDTH      = 4;

    localparam logic [MEM_DATA_WIDTH-1:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [FMT_WIDTH-1:0] {
        FMT_LUI    = 4'd0,
        FMT_AUIPC  = 4'd1,
        FMT_JAL    = 4'd2,
        FMT_JALR   = 4'd3,
        FMT_BRANCH = 4'd4,
        FMT_LOAD   = 4'd5,
        FMT_STORE  = 4'd6,
        FMT_IMM    = 4'd7,
        FMT_ALU    = 4'd8
    } fmt_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
    localparam logic [6:0] OPCODE_ALU    = 7'b0110011;

    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

endpackage

// File: rtl/instr_word_encoder_imm_range_check.sv
// Decides whether a decoded field bundle can be expressed as a legal RV32I
// word: immediate range/alignment plus reserved funct3/alt combinations.
module instr_word_encoder_imm_range_check
    import instr_word_encoder_pkg::*;
(
    input  logic [FMT_WIDTH-1:0]      fmt_i,
    input  logic [2:0]                funct3_i,
    input  logic                      alt_i,
    input  logic [MEM_DATA_WIDTH-1:0] imm_i,
    output logic                      err_o
);

    logic signed [MEM_DATA_WIDTH-1:0] simm;
    logic                             iTypeBad;

    assign simm = $signed(imm_i);

    always_comb begin
        iTypeBad = (simm < -32'sd2048) || (simm > 32'sd2047);
        err_o    = 1'b1;
        case (fmt_i)
            FMT_LUI, FMT_AUIPC: err_o = (imm_i[11:0] != 12'h000);
            FMT_JAL:  err_o = imm_i[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
            FMT_JALR: err_o = iTypeBad;
            FMT_LOAD: err_o = iTypeBad || (funct3_i == 3'b011) || (funct3_i == 3'b110)
                              || (funct3_i == 3'b111);
            FMT_BRANCH: err_o = imm_i[0] || (simm < -32'sd4096) || (simm > 32'sd4094)
                                || (funct3_i == 3'b010) || (funct3_i == 3'b011);
            FMT_STORE: err_o = iTypeBad || (funct3_i > 3'b010);
            FMT_IMM: begin
                // Shifts carry a 5-bit shamt; only SRAI may set the alt bit
                if (funct3_i == FUNCT3_SLL || funct3_i == FUNCT3_SR) begin
                    err_o = (simm < 32'sd0) || (simm > 32'sd31)
                            || ((funct3_i == FUNCT3_SLL) && alt_i);
                end else begin
                    err_o = iTypeBad;
                end
            end
            FMT_ALU: err_o = alt_i && (funct3_i != FUNCT3_ADD) && (funct3_i != FUNCT3_SR);
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Two-stage valid/ready encoder that packs decoded RV32I fields into
// instruction words and stamps each with its instruction-memory address.
module instr_word_encoder
    import instr_word_encoder_pkg::*;
#(
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                        ERR_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FMT_WIDTH-1:0]      in_fmt,
    input  logic [2:0]                in_funct3,
    input  logic                      in_alt,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [MEM_DATA_WIDTH-1:0] in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MEM_DATA_WIDTH-1:0] out_instr,
    output logic [MEM_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_err,
    output logic [ERR_CNT_WIDTH-1:0]  err_count
);

    logic                      s1Valid_q;
    logic                      s1Err_q;
    logic [FMT_WIDTH-1:0]      s1Fmt_q;
    logic [2:0]                s1Funct3_q;
    logic                      s1Alt_q;
    logic [REG_ADDR_WIDTH-1:0] s1Rd_q;
    logic [REG_ADDR_WIDTH-1:0] s1Rs1_q;
    logic [REG_ADDR_WIDTH-1:0] s1Rs2_q;
    logic [MEM_DATA_WIDTH-1:0] s1Imm_q;
    logic                      s2Valid_q;
    logic                      s2Err_q;
    logic [MEM_DATA_WIDTH-1:0] s2Instr_q;
    logic [MEM_DATA_WIDTH-1:0] s2Instr_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [ERR_CNT_WIDTH-1:0]  errCount_q;
    logic                      inErr;
    logic                      advance;
    logic                      outXfer;

    instr_word_encoder_imm_range_check u_rangeCheck (
        .fmt_i    (in_fmt),
        .funct3_i (in_funct3),
        .alt_i    (in_alt),
        .imm_i    (in_imm),
        .err_o    (inErr)
    );

    // Stall-all pipeline: S1 may only move when S2 is empty or draining
    assign advance  = !s2Valid_q || out_ready;
    assign in_ready = !clear && advance;
    assign outXfer  = s2Valid_q && out_ready;

    always_comb begin
        s2Instr_d = INSTR_NOP;
        case (s1Fmt_q)
            FMT_LUI:   s2Instr_d = {s1Imm_q[31:12], s1Rd_q, OPCODE_LUI};
            FMT_AUIPC: s2Instr_d = {s1Imm_q[31:12], s1Rd_q, OPCODE_AUIPC};
            FMT_JAL:   s2Instr_d = {s1Imm_q[20], s1Imm_q[10:1], s1Imm_q[11], s1Imm_q[19:12],
                                    s1Rd_q, OPCODE_JAL};
            FMT_JALR:  s2Instr_d = {s1Imm_q[11:0], s1Rs1_q, s1Funct3_q, s1Rd_q, OPCODE_JALR};
            FMT_LOAD:  s2Instr_d = {s1Imm_q[11:0], s1Rs1_q, s1Funct3_q, s1Rd_q, OPCODE_LOAD};
            FMT_BRANCH: s2Instr_d = {s1Imm_q[12], s1Imm_q[10:5], s1Rs2_q, s1Rs1_q, s1Funct3_q,
                                     s1Imm_q[4:1], s1Imm_q[11], OPCODE_BRANCH};
            FMT_STORE: s2Instr_d = {s1Imm_q[11:5], s1Rs2_q, s1Rs1_q, s1Funct3_q, s1Imm_q[4:0],
                                    OPCODE_STORE};
            FMT_IMM: begin
                if (s1Funct3_q == FUNCT3_SLL || s1Funct3_q == FUNCT3_SR) begin
                    s2Instr_d = {1'b0, s1Alt_q, 5'b00000, s1Imm_q[4:0], s1Rs1_q, s1Funct3_q,
                                 s1Rd_q, OPCODE_IMM};
                end else begin
                    s2Instr_d = {s1Imm_q[11:0], s1Rs1_q, s1Funct3_q, s1Rd_q, OPCODE_IMM};
                end
            end
            FMT_ALU: s2Instr_d = {1'b0, s1Alt_q, 5'b00000, s1Rs2_q, s1Rs1_q, s1Funct3_q,
                                  s1Rd_q, OPCODE_ALU};
            default: s2Instr_d = INSTR_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s2Instr_q  <= INSTR_NOP;
            s2Err_q    <= 1'b0;
            addr_q     <= BASE_ADDR;
            errCount_q <= '0;
        end else if (clear) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            addr_q     <= BASE_ADDR;
            errCount_q <= '0;
        end else begin
            if (outXfer) begin
                addr_q <= addr_q + MEM_ADDR_WIDTH'(4);
                if (s2Err_q && (errCount_q != '1)) begin
                    errCount_q <= errCount_q + 1'b1;
                end
            end
            if (advance) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Instr_q <= s1Err_q ? INSTR_NOP : s2Instr_d;
                    s2Err_q   <= s1Err_q;
                end
                s1Valid_q <= in_valid;
                if (in_valid) begin
                    s1Err_q    <= inErr;
                    s1Fmt_q    <= in_fmt;
                    s1Funct3_q <= in_funct3;
                    s1Alt_q    <= in_alt;
                    s1Rd_q     <= in_rd;
                    s1Rs1_q    <= in_rs1;
                    s1Rs2_q    <= in_rs2;
                    s1Imm_q    <= in_imm;
                end
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_instr = s2Instr_q;
    assign out_err   = s2Err_q;
    assign out_addr  = addr_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: hand-encoded words, error bundles,
// backpressure streaming, clear and reset behaviour.
module tb_instr_word_encoder;
    import instr_word_encoder_pkg::*;

    typedef struct packed {
        logic [3:0]  fmt;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_ready, in_alt;
    logic [3:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;
    int          checks = 0;
    int          errors = 0;

    instr_word_encoder #(.BASE_ADDR(32'h0), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Drives one bundle (called just after a rising edge with out_ready high)
    // and captures what appears two edges later.
    task automatic runOne(input vec_t v, output logic [31:0] instr, output logic [31:0] addr,
                          output logic err, output logic early, output logic late);
        in_fmt = v.fmt; in_funct3 = v.f3; in_alt = v.alt;
        in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        early = out_valid;
        @(posedge clk); #1;
        late = out_valid; instr = out_instr; addr = out_addr; err = out_err;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h00000013) begin errors++; $display("[TB] FAIL reset out_instr: got %h want 00000013", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset out_addr: got %h want 0", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset out_err: got %b want 0", out_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset err_count: got %0d want 0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_encodings();
        vec_t        v [7];
        logic [31:0] instr, addr;
        logic        err, early, late;
        v[0] = '{4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0};
        v[1] = '{4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b0};
        v[2] = '{4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0};
        v[3] = '{4'd8, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0};
        v[4] = '{4'd6, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0};
        v[5] = '{4'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0};
        v[6] = '{4'd5, 3'b010, 1'b0, 5'd4, 5'd3, 5'd0, 32'hFFFFFFFF,   32'hFFF1A203, 1'b0};
        for (int i = 0; i < 7; i++) begin
            runOne(v[i], instr, addr, err, early, late);
            checks++; if (early !== 1'b0 || late !== 1'b1) begin errors++; $display("[TB] FAIL enc%0d latency: got valid %b/%b want 0/1", i, early, late); end
            checks++; if (instr !== v[i].exp) begin errors++; $display("[TB] FAIL enc%0d instr: got %h want %h", i, instr, v[i].exp); end
            checks++; if (addr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL enc%0d addr: got %h want %h", i, addr, 32'(4 * i)); end
            checks++; if (err !== v[i].expErr) begin errors++; $display("[TB] FAIL enc%0d err: got %b want %b", i, err, v[i].expErr); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] gotInstr [6];
        logic [31:0] gotAddr [6];
        logic [31:0] expInstr;
        int          nGot;
        logic        sawStall;
        nGot = 0; sawStall = 1'b0;
        pulseClear();
        fork
            begin : driver
                logic acc;
                int   budget;
                for (int i = 0; i < 6; i++) begin
                    in_fmt = 4'd7; in_funct3 = 3'b000; in_alt = 1'b0;
                    in_rd = 5'(i + 1); in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'(i);
                    in_valid = 1'b1;
                    acc = 1'b0; budget = 0;
                    while (!acc && budget < 20) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!in_ready) sawStall = 1'b1;
                        @(posedge clk); #1;
                        budget++;
                    end
                end
                in_valid = 1'b0;
            end
            begin : monitor
                for (int c = 0; c < 60 && nGot < 6; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        gotInstr[nGot] = out_instr;
                        gotAddr[nGot]  = out_addr;
                        nGot++;
                    end
                end
            end
            begin : readyCtl
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        @(posedge clk); #1;
        checks++; if (nGot !== 6) begin errors++; $display("[TB] FAIL stream count: got %0d want 6", nGot); end
        checks++; if (sawStall !== 1'b1) begin errors++; $display("[TB] FAIL stream in_ready drop: got %b want 1", sawStall); end
        for (int i = 0; i < nGot; i++) begin
            expInstr = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            checks++; if (gotInstr[i] !== expInstr) begin errors++; $display("[TB] FAIL stream%0d instr: got %h want %h", i, gotInstr[i], expInstr); end
            checks++; if (gotAddr[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL stream%0d addr: got %h want %h", i, gotAddr[i], 32'(4 * i)); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream extra word: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_errors();
        vec_t        v [6];
        logic [31:0] instr, addr;
        logic        err, early, late;
        v[0] = '{4'd7, 3'b001, 1'b0, 5'd1, 5'd0, 5'd0, 32'd32,   32'h00000013, 1'b1};
        v[1] = '{4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,    32'h00000013, 1'b1};
        v[2] = '{4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd2047, 32'h7FF08067, 1'b0};
        v[3] = '{4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd2048, 32'h00000013, 1'b1};
        v[4] = '{4'd7, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd31,   32'h41F15093, 1'b0};
        v[5] = '{4'd9, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,    32'h00000013, 1'b1};
        pulseClear();
        for (int i = 0; i < 6; i++) begin
            runOne(v[i], instr, addr, err, early, late);
            checks++; if (instr !== v[i].exp) begin errors++; $display("[TB] FAIL err%0d instr: got %h want %h", i, instr, v[i].exp); end
            checks++; if (err !== v[i].expErr) begin errors++; $display("[TB] FAIL err%0d out_err: got %b want %b", i, err, v[i].expErr); end
            checks++; if (addr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL err%0d addr: got %h want %h", i, addr, 32'(4 * i)); end
            if (i == 1) begin
                @(posedge clk); #1;
                checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL err_count after two: got %0d want 2", err_count); end
            end
        end
        @(posedge clk); #1;
        checks++; if (err_count !== 8'd4) begin errors++; $display("[TB] FAIL err_count final: got %0d want 4", err_count); end
    endtask

    task automatic pushTwoStalled(input logic [31:0] firstImm);
        out_ready = 1'b0;
        in_fmt = 4'd7; in_funct3 = 3'b000; in_alt = 1'b0;
        in_rd = 5'd7; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = firstImm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_rd = 5'd8; in_imm = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_clear();
        vec_t        v;
        logic [31:0] instr, addr;
        logic        err, early, late;
        pushTwoStalled(32'd3);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear precondition out_valid: got %b want 1", out_valid); end
        clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear out_valid: got %b want 0", out_valid); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL clear err_count: got %0d want 0", err_count); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear stale word: got out_valid %b want 0", out_valid); end
        v = '{4'd7, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd9, 32'h00900113, 1'b0};
        runOne(v, instr, addr, err, early, late);
        checks++; if (instr !== 32'h00900113) begin errors++; $display("[TB] FAIL clear next instr: got %h want 00900113", instr); end
        checks++; if (addr !== 32'h0) begin errors++; $display("[TB] FAIL clear next addr: got %h want 0", addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst();
        vec_t        v;
        logic [31:0] instr, addr;
        logic        err, early, late;
        v = '{4'd12, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1};
        runOne(v, instr, addr, err, early, late);
        @(posedge clk); #1;
        checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL rst precondition err_count: got %0d want 1", err_count); end
        pushTwoStalled(32'd5);
        rst = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; clear = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst out_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h00000013) begin errors++; $display("[TB] FAIL rst out_instr: got %h want 00000013", out_instr); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst out_addr: got %h want 0", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL rst out_err: got %b want 0", out_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL rst err_count: got %0d want 0", err_count); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst lost word reappeared: got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = 4'd0; in_funct3 = 3'b000; in_alt = 1'b0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_encodings();
        test_back_to_back();
        test_errors();
        test_clear();
        test_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
